// File: rtl/uart_pkg.sv
// Shared UART package: default baud-generator geometry and divisor type.
package uart_pkg;

  localparam int OVS_DEFAULT    = 16;
  localparam int DIV_W_DEFAULT  = 16;
  localparam int FRAC_W_DEFAULT = 4;

  typedef logic [DIV_W_DEFAULT-1:0] baud_div_t;

endpackage

// File: rtl/uart_mod_counter.sv
// Modulo counter: counts 0..term while enabled, wraps to 0 on reaching term.
module uart_mod_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // >= so a term lowered below the count wraps instead of stalling
  assign wrap = en & ~clr & (cnt_q >= term);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud tick generator: prescaler -> oversample tick -> bit-centre/boundary strobes.
// Fractional divisor enabled with `define UART_BAUD_GEN_FRAC_EN.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEFAULT,
  parameter int OVS    = OVS_DEFAULT,
  parameter int FRAC_W = FRAC_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   sync_clr,
  input  logic [DIV_W-1:0]       div_int,
  input  logic [FRAC_W-1:0]      div_frac,
  output logic                   os_tick,
  output logic                   mid_tick,
  output logic                   bit_tick,
  output logic [$clog2(OVS)-1:0] os_cnt
);

  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] OS_LAST = OW'(OVS - 1);
  localparam logic [OW-1:0] OS_MID  = OW'(OVS / 2 - 1);

  logic             run;
  logic             ext;
  logic [DIV_W-1:0] pre_term;
  logic [DIV_W-1:0] pre_cnt;
  logic             pre_wrap;
  logic             os_wrap;
  logic             os_tick_q;
  logic             mid_tick_q;
  logic             bit_tick_q;

  assign run      = en & (div_int != '0);
  assign pre_term = div_int - DIV_W'(1) + DIV_W'(ext);

  uart_mod_counter #(.WIDTH(DIV_W)) u_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run),
    .clr     (sync_clr),
    .term    (pre_term),
    .cnt     (pre_cnt),
    .wrap    (pre_wrap)
  );

  uart_mod_counter #(.WIDTH(OW)) u_os (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pre_wrap),
    .clr     (sync_clr),
    .term    (OS_LAST),
    .cnt     (os_cnt),
    .wrap    (os_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else if (sync_clr) begin
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      os_tick_q  <= pre_wrap;
      mid_tick_q <= pre_wrap & (os_cnt == OS_MID);
      bit_tick_q <= os_wrap;
    end
  end

  assign os_tick  = os_tick_q;
  assign mid_tick = mid_tick_q;
  assign bit_tick = bit_tick_q;

`ifdef UART_BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] frac_q;
  logic              ext_q;
  logic [FRAC_W:0]   frac_sum;

  // carry out stretches the next prescaler period by one clk
  assign frac_sum = {1'b0, frac_q} + {1'b0, div_frac};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frac_q <= '0;
      ext_q  <= 1'b0;
    end else if (sync_clr) begin
      frac_q <= '0;
      ext_q  <= 1'b0;
    end else if (pre_wrap) begin
      {ext_q, frac_q} <= frac_sum;
    end
  end

  assign ext = ext_q;

  logic unused_ok;
  assign unused_ok = ^pre_cnt;
`else
  assign ext = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{pre_cnt, div_frac};
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: latency, strobe phasing, hold, clear, reset.
module tb_uart_baud_gen;
  import uart_pkg::*;

  logic      clk      = 1'b0;
  logic      reset_n  = 1'b0;
  logic      en       = 1'b0;
  logic      sync_clr = 1'b0;
  baud_div_t div_int  = '0;
  logic [3:0] div_frac = '0;
  logic      os_tick;
  logic      mid_tick;
  logic      bit_tick;
  logic [3:0] os_cnt;

  int vecs = 0;
  int errs = 0;

  uart_baud_gen #(
    .DIV_W  (16),
    .OVS    (16),
    .FRAC_W (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .sync_clr (sync_clr),
    .div_int  (div_int),
    .div_frac (div_frac),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .os_cnt   (os_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
  endtask

  // cycles until os_tick, -1 if none within lim
  task automatic wait_tick(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (os_tick) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, cyc, ticks, mid_at, bit_at, bit_c1, bit_c2, bit_os;
    int ones, stb;

    #12;
    chk("rst_os_tick", int'(os_tick), 0);
    chk("rst_mid_tick", int'(mid_tick), 0);
    chk("rst_bit_tick", int'(bit_tick), 0);
    chk("rst_os_cnt", int'(os_cnt), 0);
    reset_n = 1'b1;

    // div 4: tick every 4, mid on 8th tick, bit on 16th
    div_int = 16'd4;
    en      = 1'b1;
    do_clr();
    wait_tick(20, n);
    chk("lat_div4", n, 4);
    chk("oscnt_first", int'(os_cnt), 1);
    cyc = 4; ticks = 1; mid_at = 0; bit_at = 0;
    bit_c1 = 0; bit_c2 = 0; bit_os = -1;
    for (int i = 0; i < 130; i++) begin
      step();
      cyc++;
      if (os_tick) ticks++;
      if (mid_tick && mid_at == 0) mid_at = ticks;
      if (bit_tick) begin
        if (bit_c1 == 0) begin
          bit_c1 = cyc;
          bit_at = ticks;
          bit_os = int'(os_cnt);
        end else if (bit_c2 == 0) begin
          bit_c2 = cyc;
        end
      end
    end
    chk("mid_tick_idx", mid_at, 8);
    chk("bit_tick_idx", bit_at, 16);
    chk("bit_first_cyc", bit_c1, 64);
    chk("bit_period", bit_c2 - bit_c1, 64);
    chk("oscnt_wrap", bit_os, 0);
    chk("ticks_134cyc", ticks, 33);

    // div 1: tick every cycle, en low holds
    div_int = 16'd1;
    do_clr();
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      ones += int'(os_tick);
    end
    chk("div1_ticks", ones, 10);
    en = 1'b0;
    stb = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      stb += int'(os_tick) + int'(mid_tick) + int'(bit_tick);
    end
    chk("en0_strobes", stb, 0);
    chk("en0_hold", int'(os_cnt), 10);
    en = 1'b1;
    step();
    chk("en1_resume", int'(os_cnt), 11);

    // lower div 10 -> 3 at pre_cnt 7, then stop
    div_int = 16'd10;
    do_clr();
    ones = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      ones += int'(os_tick);
    end
    chk("div10_quiet", ones, 0);
    div_int = 16'd3;
    step();
    chk("lower_tick", int'(os_tick), 1);
    wait_tick(10, n);
    chk("lower_period", n, 3);
    div_int = 16'd0;
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ones += int'(os_tick) + int'(mid_tick) + int'(bit_tick);
    end
    chk("div0_ticks", ones, 0);
    chk("div0_hold", int'(os_cnt), 2);

    // sync_clr with en at os_cnt 9
    div_int = 16'd1;
    do_clr();
    repeat (9) step();
    chk("pre_clr_cnt", int'(os_cnt), 9);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("clr_os_cnt", int'(os_cnt), 0);
    chk("clr_strobes", int'({os_tick, mid_tick, bit_tick}), 0);
    div_int = 16'd2;
    wait_tick(10, n);
    chk("clr_restart", n, 2);
    chk("clr_restart_cnt", int'(os_cnt), 1);

    // async reset mid-count
    div_int = 16'd1;
    do_clr();
    repeat (3) step();
    div_int = 16'd10;
    repeat (5) step();
    chk("pre_rst_cnt", int'(os_cnt), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_cnt", int'(os_cnt), 0);
    chk("rst_async_stb", int'({os_tick, mid_tick, bit_tick}), 0);
    #2 reset_n = 1'b1;
    do_clr();
    wait_tick(20, n);
    chk("rst_relatency", n, 10);

`ifdef UART_BAUD_GEN_FRAC_EN
    begin
      int exp_cyc, acc, ext, sum;
      exp_cyc = 0; acc = 0; ext = 0;
      for (int i = 0; i < 16; i++) begin
        exp_cyc += 6 + ext;
        sum = acc + 8;
        ext = sum / 16;
        acc = sum % 16;
      end
      div_int  = 16'd6;
      div_frac = 4'd8;
      do_clr();
      cyc = 0; ticks = 0;
      while (ticks < 16 && cyc < 300) begin
        step();
        cyc++;
        if (os_tick) ticks++;
      end
      chk("frac_16ticks", cyc, exp_cyc);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
